fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//   Instruction-fetch sequencer for the RISC core; the supplier of ins/pc and the consumer of nextpc.
//   Owns the program counter and reads the word-addressed instruction memory (synchronous read, 1-cycle latency).
//   Presents ins/pc to decode/execute with a valid flag, then waits for execute to return nextpc.
//   Tracks the halt opcode and counts retired instructions.
// PARAMETERS
//   IMEM_AW   8        instruction-memory word-address width; imem_addr = pc[IMEM_AW-1:0]
//   RESET_PC  32'd0    pc value loaded on reset
//   HALT_OP   6'h3f    opcode (ins[31:26]) that halts the core once it retires
// PORTS
//   clk          in   1        clock, all state updates on rising edge
//   rst_n        in   1        asynchronous, active-low reset
//   run          in   1        1 = fetch allowed; sampled only in IDLE and at ISSUE exit
//   imem_addr    out  IMEM_AW  registered instruction-memory word address
//   imem_rdata   in   32       instruction word, valid the cycle after imem_addr is sampled
//   ins          out  32       registered instruction presented to decode/execute
//   pc           out  32       word address of ins
//   ins_valid    out  1        ins/pc valid and held stable
//   exec_done    in   1        execute has finished ins; nextpc valid this cycle
//   nextpc       in   32       pc of the next instruction (pc+1, branch target, j/jal/jr target)
//   halted       out  1        HALT_OP instruction has retired
//   instr_count  out  32       retired-instruction counter
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE, pc=RESET_PC, imem_addr=RESET_PC[IMEM_AW-1:0], ins=0,
//     ins_valid=0, halted=0, instr_count=0. Reset mid-fetch discards the in-flight read.
//   States: IDLE, ADDR, DATA, ISSUE, HALT.
//   IDLE : run=1 -> ADDR, imem_addr<=pc[IMEM_AW-1:0]; run=0 -> stay.
//   ADDR : memory samples imem_addr at end of cycle -> DATA (unconditional).
//   DATA : ins<=imem_rdata, ins_valid<=1 -> ISSUE (unconditional).
//   ISSUE: ins/pc/ins_valid held until exec_done=1. On exec_done:
//     instr_count+=1 (wraps at 2^32); ins_valid<=0;
//     if ins[31:26]==HALT_OP -> HALT, halted<=1, pc unchanged;
//     else pc<=nextpc; run=1 -> ADDR, imem_addr<=nextpc[IMEM_AW-1:0]; run=0 -> IDLE.
//   HALT : terminal until reset; ins_valid=0, imem_addr frozen, run/exec_done ignored.
//   Latency: run=1 in IDLE cycle N -> ins_valid=1 in cycle N+3; exec_done in ISSUE cycle M
//     -> next ins_valid=1 in cycle M+3 (run=1).
//   exec_done outside ISSUE is ignored. run=0 during ADDR/DATA does not abort the fetch.
//   pc is full 32 bits; only imem_addr truncates (wrap-around modulo 2^IMEM_AW).
//   ins_valid=1 exactly while in ISSUE.
// TESTING
//   1. Reset, imem[0]=32'h04220005, run=1 -> ins_valid high 3 cycles later, ins=32'h04220005, pc=0.
//   2. In ISSUE, exec_done=1, nextpc=1, imem[1]=32'h00430820 -> pc=1, ins=32'h00430820, instr_count=1.
//   3. nextpc=32'h00000105 (IMEM_AW=8) -> imem_addr=8'h05, pc=32'h00000105, ins=imem[5].
//   4. run=0 at exec_done, nextpc=7 -> IDLE, ins_valid=0, pc=7; run=1 later -> ins=imem[7] 3 cycles on.
//   5. ins=32'hFC000000 retires -> halted=1, instr_count+1, further exec_done/run ignored, imem_addr frozen.
//   6. rst_n low during DATA -> outputs at reset values same cycle; no ins latch; restart fetches RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: owns the pc and reads a synchronous
// instruction memory with 1-cycle latency. It presents ins/pc with a valid
// flag, waits for execute to return nextpc, and stops on the halt opcode.
module fetch_unit #(
   parameter int          IMEM_AW  = 8,
   parameter logic [31:0] RESET_PC = 32'd0,
   parameter logic [5:0]  HALT_OP  = 6'h3f
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               run,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [31:0]        imem_rdata,
   output logic [31:0]        ins,
   output logic [31:0]        pc,
   output logic               ins_valid,
   input  logic               exec_done,
   input  logic [31:0]        nextpc,
   output logic               halted,
   output logic [31:0]        instr_count
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] ADDR  = 3'd1;
   localparam logic [2:0] DATA  = 3'd2;
   localparam logic [2:0] ISSUE = 3'd3;
   localparam logic [2:0] HALT  = 3'd4;

   logic [2:0] state;

   // Fetch sequencer. ADDR and DATA always run to completion, so a late
   // drop of run never leaves a half-finished read. ins_valid is set on
   // entry to ISSUE and cleared on exit, which makes it track ISSUE exactly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         imem_addr   <= RESET_PC[IMEM_AW-1:0];
         ins         <= 32'd0;
         ins_valid   <= 1'b0;
         halted      <= 1'b0;
         instr_count <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (run) begin
                  state     <= ADDR;
                  imem_addr <= pc[IMEM_AW-1:0];
               end
            end
            // Memory samples imem_addr at the end of this cycle.
            ADDR: state <= DATA;
            DATA: begin
               ins       <= imem_rdata;
               ins_valid <= 1'b1;
               state     <= ISSUE;
            end
            ISSUE: begin
               if (exec_done) begin
                  instr_count <= instr_count + 32'd1;
                  ins_valid   <= 1'b0;
                  if (ins[31:26] == HALT_OP) begin
                     // pc stays on the halt instruction for debug visibility.
                     state  <= HALT;
                     halted <= 1'b1;
                  end else begin
                     pc <= nextpc;
                     if (run) begin
                        state     <= ADDR;
                        imem_addr <= nextpc[IMEM_AW-1:0];
                     end else begin
                        state <= IDLE;
                     end
                  end
               end
            end
            // Terminal until reset; all inputs ignored.
            HALT: state <= HALT;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a behavioural synchronous memory, a
// scoreboard of expected {ins, pc} pairs consumed whenever ins_valid rises,
// and one task per scenario with inline checks of latency and side state.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        run = 1'b0;
   logic [7:0]  imem_addr;
   logic [31:0] imem_rdata = 32'd0;
   logic [31:0] ins;
   logic [31:0] pc;
   logic        ins_valid;
   logic        exec_done = 1'b0;
   logic [31:0] nextpc = 32'd0;
   logic        halted;
   logic [31:0] instr_count;

   logic [31:0] mem [256];
   logic [63:0] sb_q [$];

   int errors = 0;
   int checks = 0;
   int sb_err = 0;
   int sb_chk = 0;

   fetch_unit #(.IMEM_AW(8), .RESET_PC(32'd0), .HALT_OP(6'h3f)) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .ins(ins), .pc(pc), .ins_valid(ins_valid),
      .exec_done(exec_done), .nextpc(nextpc), .halted(halted),
      .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   // Synchronous-read instruction memory, 1-cycle latency.
   always @(posedge clk) imem_rdata <= mem[imem_addr];

   // Scoreboard consumer: every rising edge of ins_valid pops one expectation.
   initial begin
      logic        prev_v;
      logic [63:0] exp_v;
      prev_v = 1'b0;
      forever begin
         @(negedge clk);
         if (ins_valid === 1'b1 && prev_v !== 1'b1) begin
            sb_chk++;
            if (sb_q.size() == 0) begin
               sb_err++;
               $display("FAIL sb_unexpected: ins=%h pc=%h but nothing expected", ins, pc);
            end else begin
               exp_v = sb_q.pop_front();
               if ({ins, pc} !== exp_v) begin
                  sb_err++;
                  $display("FAIL sb_issue: ins=%h pc=%h expected ins=%h pc=%h",
                           ins, pc, exp_v[63:32], exp_v[31:0]);
               end
            end
         end
         prev_v = ins_valid;
      end
   end

   task automatic pulse_exec(input logic [31:0] npc, input logic r);
      @(posedge clk); #1;
      exec_done = 1'b1; nextpc = npc; run = r;
      @(posedge clk); #1;
      exec_done = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; run = 1'b0;
      #1;
      checks++; if (ins_valid !== 1'b0)    begin errors++; $display("FAIL rst_valid: got %b want 0", ins_valid); end
      checks++; if (pc !== 32'd0)          begin errors++; $display("FAIL rst_pc: got %h want 0", pc); end
      checks++; if (imem_addr !== 8'd0)    begin errors++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
      checks++; if (ins !== 32'd0)         begin errors++; $display("FAIL rst_ins: got %h want 0", ins); end
      checks++; if (halted !== 1'b0)       begin errors++; $display("FAIL rst_halted: got %b want 0", halted); end
      checks++; if (instr_count !== 32'd0) begin errors++; $display("FAIL rst_count: got %h want 0", instr_count); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (ins_valid !== 1'b0)    begin errors++; $display("FAIL idle_valid: got %b want 0", ins_valid); end
   endtask

   task automatic test_first_fetch();
      sb_q.push_back({mem[0], 32'd0});
      run = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL first_early: got %b want 0", ins_valid); end
      @(posedge clk); #1;
      checks++; if (ins_valid !== 1'b1) begin errors++; $display("FAIL first_latency: got %b want 1", ins_valid); end
      // Held stable while execute is busy.
      repeat (3) @(posedge clk); #1;
      checks++; if (ins_valid !== 1'b1 || ins !== mem[0]) begin
         errors++; $display("FAIL first_hold: valid=%b ins=%h want 1 %h", ins_valid, ins, mem[0]);
      end
   endtask

   task automatic test_next_seq();
      sb_q.push_back({mem[1], 32'd1});
      pulse_exec(32'd1, 1'b1);
      checks++; if (ins_valid !== 1'b0 || instr_count !== 32'd1) begin
         errors++; $display("FAIL next_retire: valid=%b count=%0d want 0 1", ins_valid, instr_count);
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++; if (ins_valid !== 1'b1 || pc !== 32'd1) begin
         errors++; $display("FAIL next_latency: valid=%b pc=%h want 1 1", ins_valid, pc);
      end
   endtask

   task automatic test_addr_wrap();
      sb_q.push_back({mem[5], 32'h0000_0105});
      pulse_exec(32'h0000_0105, 1'b1);
      checks++; if (imem_addr !== 8'h05 || pc !== 32'h0000_0105) begin
         errors++; $display("FAIL wrap_addr: addr=%h pc=%h want 05 00000105", imem_addr, pc);
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++; if (ins_valid !== 1'b1 || instr_count !== 32'd2) begin
         errors++; $display("FAIL wrap_issue: valid=%b count=%0d want 1 2", ins_valid, instr_count);
      end
   endtask

   task automatic test_idle_restart();
      pulse_exec(32'd7, 1'b0);
      checks++; if (ins_valid !== 1'b0 || pc !== 32'd7 || instr_count !== 32'd3) begin
         errors++; $display("FAIL idle_enter: valid=%b pc=%h count=%0d want 0 7 3", ins_valid, pc, instr_count);
      end
      // exec_done outside ISSUE must not retire anything.
      pulse_exec(32'd9, 1'b0);
      repeat (3) @(posedge clk); #1;
      checks++; if (ins_valid !== 1'b0 || instr_count !== 32'd3 || pc !== 32'd7) begin
         errors++; $display("FAIL idle_stay: valid=%b count=%0d pc=%h want 0 3 7", ins_valid, instr_count, pc);
      end
      // Single-cycle run; dropping it during ADDR/DATA must not abort.
      sb_q.push_back({mem[7], 32'd7});
      run = 1'b1;
      @(posedge clk); #1;
      run = 1'b0;
      @(posedge clk); #1;
      checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL restart_early: got %b want 0", ins_valid); end
      @(posedge clk); #1;
      checks++; if (ins_valid !== 1'b1) begin errors++; $display("FAIL restart_latency: got %b want 1", ins_valid); end
   endtask

   task automatic test_halt();
      int n;
      sb_q.push_back({mem[8], 32'd8});
      pulse_exec(32'd8, 1'b1);
      n = 0;
      while (ins_valid !== 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
      checks++; if (ins_valid !== 1'b1) begin errors++; $display("FAIL halt_fetch: timeout valid=%b", ins_valid); end
      @(posedge clk); #1;
      exec_done = 1'b1; nextpc = 32'h55; run = 1'b1;
      @(posedge clk); #1;
      checks++; if (halted !== 1'b1 || instr_count !== 32'd5 || ins_valid !== 1'b0) begin
         errors++; $display("FAIL halt_retire: halted=%b count=%0d valid=%b want 1 5 0", halted, instr_count, ins_valid);
      end
      repeat (6) @(posedge clk); #1;
      checks++; if (instr_count !== 32'd5 || ins_valid !== 1'b0 || imem_addr !== 8'd8 || pc !== 32'd8) begin
         errors++; $display("FAIL halt_frozen: count=%0d valid=%b addr=%h pc=%h want 5 0 08 8",
                            instr_count, ins_valid, imem_addr, pc);
      end
      exec_done = 1'b0; run = 1'b0;
   endtask

   task automatic test_reset_mid();
      int n;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1; run = 1'b1;
      @(posedge clk); #1;   // ADDR
      @(posedge clk); #1;   // DATA
      rst_n = 1'b0;
      #1;
      checks++; if (halted !== 1'b0 || instr_count !== 32'd0 || pc !== 32'd0 || ins_valid !== 1'b0) begin
         errors++; $display("FAIL midrst_async: halted=%b count=%0d pc=%h valid=%b want 0 0 0 0",
                            halted, instr_count, pc, ins_valid);
      end
      @(posedge clk); #1;
      checks++; if (ins !== 32'd0) begin errors++; $display("FAIL midrst_ins: got %h want 0", ins); end
      sb_q.push_back({mem[0], 32'd0});
      rst_n = 1'b1;
      n = 0;
      while (ins_valid !== 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
      checks++; if (ins_valid !== 1'b1 || n != 3) begin
         errors++; $display("FAIL midrst_restart: valid=%b cycles=%0d want 1 3", ins_valid, n);
      end
      run = 1'b0;
      @(negedge clk); @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = {16'h00A5, 8'h5A, i[7:0]};
      mem[0] = 32'h0422_0005;
      mem[1] = 32'h0043_0820;
      mem[5] = 32'h1234_0005;
      mem[7] = 32'h2000_0007;
      mem[8] = 32'hFC00_0000;
      test_reset();
      test_first_fetch();
      test_next_seq();
      test_addr_wrap();
      test_idle_restart();
      test_halt();
      test_reset_mid();
      checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL sb_leftover: %0d pending want 0", sb_q.size()); end
      errors += sb_err;
      checks += sb_chk;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
